// File: rtl/serial_pkg.sv
// Shared definitions for the LSB-first serializer: FSM state type and default word width.
package serial_pkg;

   localparam int unsigned SER_W = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/lsb_serializer.sv
// Parallel-to-serial converter, LSB first, with a one-entry holding register so that
// back-to-back words produce contiguous frames framed by sof/eof.
module lsb_serializer
   import serial_pkg::*;
#(
   parameter int unsigned W = SER_W
) (
   input  logic         t_clk,
   input  logic         r,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         so,
   output logic         sof,
   output logic         eof,
   output logic         busy
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t        state;
   logic [W-1:0]  sh;
   logic [CW-1:0] cnt;
   logic [W-1:0]  pend;
   logic          pend_v;

   logic last_bit;
   logic load;
   logic xfer;

   always_comb begin
      last_bit  = (state == SHIFT) && (cnt == LAST);
      load      = pend_v && ((state == IDLE) || last_bit);
      din_ready = (!pend_v || load) && !r;
      xfer      = din_valid && din_ready;
   end

   // The holding register refills on the same edge it hands its word to the shifter.
   always_ff @(posedge t_clk) begin
      if (r) begin
         state  <= IDLE;
         sh     <= '0;
         cnt    <= '0;
         pend   <= '0;
         pend_v <= 1'b0;
      end else begin
         if (xfer) begin
            pend   <= din;
            pend_v <= 1'b1;
         end else if (load) begin
            pend_v <= 1'b0;
         end

         if (load) begin
            sh    <= pend;
            cnt   <= '0;
            state <= SHIFT;
         end else if (state == SHIFT) begin
            sh <= sh >> 1;
            if (last_bit) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy = (state == SHIFT);
      so   = busy && sh[0];
      sof  = busy && (cnt == '0);
      eof  = last_bit;
   end

endmodule

// File: tb/tb_lsb_serializer.sv
// Self-checking bench for lsb_serializer: directed scenarios plus random traffic against a
// queue-based model of accepted words and frames in flight.
module tb_lsb_serializer;

   localparam int W = 8;

   logic         t_clk;
   logic         r;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         so;
   logic         sof;
   logic         eof;
   logic         busy;

   lsb_serializer #(.W(W)) dut (
      .t_clk     (t_clk),
      .r         (r),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .so        (so),
      .sof       (sof),
      .eof       (eof),
      .busy      (busy)
   );

   initial t_clk = 1'b0;
   always #5 t_clk = ~t_clk;

   int total = 0;
   int bad   = 0;

   // Model: words waiting to start, and the frame currently on the line.
   logic [W-1:0] waitq[$];
   logic [W-1:0] cur;
   logic         active = 1'b0;
   int           pos = 0;
   logic         last_acc;

   // Bits actually observed on so while busy, and the downstream two's-complement stage.
   logic         stream[$];
   logic         tc_seen;
   logic [W-1:0] tc_word;
   int           tc_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [W-1:0] d, input logic rr);
      logic exp_rdy;
      logic acc;
      @(negedge t_clk);
      din_valid = v;
      din       = d;
      r         = rr;
      #1;
      exp_rdy = !rr && (waitq.size() == 0 || !active || pos == W - 1);
      chk("din_ready", {31'd0, din_ready}, {31'd0, exp_rdy});
      acc      = v && exp_rdy;
      last_acc = acc;
      @(posedge t_clk);
      if (rr) begin
         waitq.delete();
         active = 1'b0;
         pos    = 0;
      end else begin
         if (active) begin
            pos++;
            if (pos == W) active = 1'b0;
         end
         if (!active && waitq.size() > 0) begin
            cur    = waitq.pop_front();
            active = 1'b1;
            pos    = 0;
         end
         if (acc) waitq.push_back(d);
      end
      #1;
      chk("busy", {31'd0, busy}, {31'd0, active});
      chk("so",   {31'd0, so},   {31'd0, active && cur[pos]});
      chk("sof",  {31'd0, sof},  {31'd0, active && pos == 0});
      chk("eof",  {31'd0, eof},  {31'd0, active && pos == W - 1});
      if (busy) begin
         stream.push_back(so);
         if (sof) begin
            tc_seen = 1'b0;
            tc_idx  = 0;
         end
         if (tc_idx < W) tc_word[tc_idx] = tc_seen ? ~so : so;
         tc_seen = tc_seen | so;
         tc_idx++;
      end
   endtask

   function automatic logic [31:0] pack_stream();
      logic [31:0] v = '0;
      for (int i = 0; i < stream.size() && i < 32; i++) v[i] = stream[i];
      return v;
   endfunction

   initial begin
      din_valid = 1'b0;
      din       = '0;
      r         = 1'b1;
      tc_seen   = 1'b0;
      tc_word   = '0;
      tc_idx    = 0;

      // Reset, then ready with all outputs low.
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      chk("reset_ready", {31'd0, din_ready}, 32'd1);

      // Single word 0x06.
      stream.delete();
      cyc(1'b1, 8'h06, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0);
      chk("w06_bits", 32'(stream.size()), 32'd8);
      chk("w06_word", pack_stream(), 32'h06);
      chk("w06_twos", {24'd0, tc_word}, 32'hFA);

      // Back-to-back A5, 3C, then FF offered while a word is pending.
      stream.delete();
      cyc(1'b1, 8'hA5, 1'b0);
      cyc(1'b1, 8'h3C, 1'b0);
      last_acc = 1'b0;
      for (int i = 0; i < 12 && !last_acc; i++) cyc(1'b1, 8'hFF, 1'b0);
      chk("ff_accepted", {31'd0, last_acc}, 32'd1);
      for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b0);
      chk("b2b_bits", 32'(stream.size()), 32'd24);
      chk("b2b_word", pack_stream(), 32'h00FF3CA5);

      // Reset while bit 4 of A5 is on the line, 3C pending.
      stream.delete();
      cyc(1'b1, 8'hA5, 1'b0);
      cyc(1'b1, 8'h3C, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0);
      chk("bit4_so", {31'd0, so}, 32'd0);
      chk("bit4_busy", {31'd0, busy}, 32'd1);
      stream.delete();
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      chk("abort_ready", {31'd0, din_ready}, 32'd1);
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0);
      chk("abort_bits", 32'(stream.size()), 32'd0);

      // Valid held during reset must not transfer.
      cyc(1'b1, 8'h55, 1'b1);
      cyc(1'b1, 8'h55, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0);
      chk("rst_valid_bits", 32'(stream.size()), 32'd0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
             W'($urandom),
             ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b0);
      chk("drain_busy", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lsb_serializer.md
LSB_SERIALIZER -- requirements
Module: lsb_serializer

Interface
REQ-001 Parameter: W, default 8, word width in bits (legal range 2..32).
REQ-002 Port: t_clk  input  1  sole clock; all flops update on rising edge.
REQ-003 Port: r  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 Port: din  input  W  parallel word to serialise, LSB sent first.
REQ-005 Port: din_valid  input  1  din holds a word offered for transfer.
REQ-006 Port: din_ready  output  1  block accepts din this cycle.
REQ-007 Port: so  output  1  serial data bit, feeds the serial two's-complement stage input.
REQ-008 Port: sof  output  1  high with bit 0 of each frame; serves as per-frame restart for the downstream stage.
REQ-009 Port: eof  output  1  high with bit W-1 of each frame.
REQ-010 Port: busy  output  1  high while a frame bit is on so.

Function
REQ-011 Transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1; din is captured into a one-entry holding register (pend, pend_v).
REQ-012 State machine SHALL have states IDLE and SHIFT; shift register sh (W bits), bit counter cnt (ceil(log2 W) bits).
REQ-013 load = pend_v and (state=IDLE or (state=SHIFT and cnt=W-1)); on load: sh<=pend, cnt<=0, state<=SHIFT.
REQ-014 din_ready SHALL equal (not pend_v or load) and not r; combinational from flops and r only, never from din_valid.
REQ-015 Simultaneous load and transfer SHALL leave pend_v=1 holding the new word; load without transfer clears pend_v.
REQ-016 In SHIFT without load: sh<=sh>>1, cnt<=cnt+1.
REQ-017 In SHIFT with cnt=W-1 and pend_v=0: state<=IDLE, cnt<=0.
REQ-018 so = sh[0] when state=SHIFT, else 0.
REQ-019 sof = (state=SHIFT and cnt=0); eof = (state=SHIFT and cnt=W-1); busy = (state=SHIFT).
REQ-020 Latency: word transferred at edge k with block idle SHALL show bit 0 on so after edge k+1.
REQ-021 Back-to-back words SHALL produce contiguous frames with no idle cycle; eof of frame n immediately followed by sof of frame n+1.
REQ-022 Word order SHALL be preserved; no word dropped or duplicated except by reset.

Reset
REQ-023 While r=1 at an edge: state<=IDLE, sh<=0, cnt<=0, pend_v<=0, pend<=0.
REQ-024 Outputs after reset edge: so=0, sof=0, eof=0, busy=0, din_ready=1 (0 while r held high).
REQ-025 Reset mid-frame SHALL abandon the current frame and discard any pending word; no partial frame resumes.

Structure
REQ-026 Shared package serial_pkg SHALL hold the state typedef (IDLE, SHIFT) and default width constant SER_W=8.
REQ-027 Single module; no sub-module is natural at this size.

Verification
REQ-028 Reset, then din=8'h06 valid one cycle -> so=0,1,1,0,0,0,0,0 over next 8 cycles; sof on cycle 1, eof on cycle 8, busy 8 cycles, then all outputs 0.
REQ-029 din=8'hA5 then 8'h3C on consecutive cycles -> 16 contiguous bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; sof at cycles 1 and 9, busy never drops.
REQ-030 Third word 8'hFF offered while pend_v=1 -> din_ready=0 until first frame's eof cycle; 8'hFF transfers then and follows 8'h3C intact.
REQ-031 r pulsed during bit 4 of frame 8'hA5 with 8'h3C pending -> next cycle so=0, busy=0, din_ready=1; 8'h3C never appears on so.
REQ-032 din_valid=1 while r=1 -> no transfer; so stays 0 after r releases.
REQ-033 so/sof driving the serial two's-complement stage, din=8'h06 -> its serial output reassembles LSB-first to 8'hFA.
